pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the pipelined CPU core. It replaces the stand-alone combinational branch-target adder with a registered PC unit that contains:
- sequential increment
- branch-target computation (base + shifted immediate)
- jump and exception redirects with fixed priority
- stall handling and a valid/ready handshake to instruction fetch
- an optional pipelined target adder for timing closure

Parameters:
DATA_W, 32, width of PC, immediate and targets
RESET_VEC, 32'h0000_0000, PC value loaded at reset
INST_BYTES, 4, sequential PC increment
IMM_SHIFT, 2, left shift applied to branch immediate
PIPE_TARGET, 0, 0 = branch target computed and applied same cycle; 1 = target registered, applied one cycle later

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_valid  out  1  pc is a valid fetch address
fetch_ready  in  1  fetch stage accepts pc this cycle
stall  in  1  hazard stall; holds PC
pc  out  DATA_W  current fetch address
pc_plus  out  DATA_W  pc + INST_BYTES (combinational)
br_req  in  1  taken branch resolved this cycle
br_base  in  DATA_W  branch base (pc_plus of branch instruction)
br_imm  in  DATA_W  sign-extended branch immediate
jmp_req  in  1  jump redirect
jmp_target  in  DATA_W  absolute jump target
exc_req  in  1  exception/interrupt redirect
exc_vec  in  DATA_W  exception vector
redirect_busy  out  1  branch target pending (PIPE_TARGET=1 only); upstream must not issue br_req/jmp_req
misalign  out  1  one-cycle pulse: accepted redirect target had nonzero bits below log2(INST_BYTES)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC, fetch_valid=0, redirect_busy=0, misalign=0, state=BOOT.
- State BOOT:
  - First clk edge with rst_n=1 sets fetch_valid=1 and moves to RUN.
  - pc is unchanged.
- Branch target:
  - Target = br_base + (br_imm << IMM_SHIFT), truncated to DATA_W; wraps modulo 2^DATA_W with no overflow flag.
  - Sequential increment also wraps, e.g. pc=32'hFFFF_FFFC -> 32'h0000_0000.
- Redirect priority: exc_req > jmp_req > br_req > sequential.
  - A redirect is accepted regardless of stall and fetch_ready.
  - A redirect discards the currently presented pc.
- Target alignment:
  - Any accepted target has its low log2(INST_BYTES) bits cleared before loading.
  - misalign pulses 1 cycle (registered, same edge as the load) if those bits were nonzero.
- RUN, PIPE_TARGET=0, at each edge:
  - Redirect accepted: pc <= target; fetch_valid stays 1.
  - Otherwise, if fetch_valid & fetch_ready & !stall: pc <= pc + INST_BYTES.
  - Otherwise pc holds. fetch_valid stays 1 and pc is stable while not accepted.
- RUN, PIPE_TARGET=1:
  - exc_req/jmp_req: behave as for PIPE_TARGET=0.
  - br_req alone: target latched into tgt_q; fetch_valid <= 0; redirect_busy <= 1; go to TGT_WAIT.
- TGT_WAIT (exactly 1 cycle), at the next edge:
  - exc_req=1: pc <= exc_vec; pending branch dropped.
  - Otherwise pc <= tgt_q.
  - In both cases fetch_valid <= 1, redirect_busy <= 0, return to RUN.
  - br_req/jmp_req in TGT_WAIT are ignored (protocol violation; bench asserts none occur).
  - stall has no effect in TGT_WAIT.
- Latency:
  - Redirect to new pc visible: 1 cycle (PIPE_TARGET=0).
  - Branch: 2 cycles (PIPE_TARGET=1).
- Reset mid-operation: immediate return to reset values; pending tgt_q discarded.

Decomposition:
- Shared package cpu_pkg: DATA_W default, INST_BYTES, RESET_VEC, state encoding (BOOT, RUN, TGT_WAIT), redirect-source encoding.
- One sub-module: pc_target_adder, parametrised on DATA_W/IMM_SHIFT, combinational base + (imm << IMM_SHIFT).
- The PIPE_TARGET register lives in pc_gen_unit.

Test Plan:
- Reset/boot: rst_n low, then released, with fetch_ready=1. Required: pc=0 and fetch_valid=0 during reset; fetch_valid=1 after 1 edge; then pc steps 0, 4, 8, 12.
- Handshake/stall:
  - At pc=0x10, drive fetch_ready=0 for 3 cycles: pc holds 0x10.
  - Then stall=1 with fetch_ready=1 for 2 cycles: pc holds.
  - Release stall: pc advances to 0x14.
- Branch, PIPE_TARGET=0: br_base=0x100, br_imm=-4 (0xFFFF_FFFC). Required: next pc=0xF0. Same test with br_imm=0x40: pc=0x200.
- Priority: exc_req, jmp_req and br_req all asserted with exc_vec=0x80, jmp_target=0x400. Required: pc=0x80. Repeat without exc_req: pc=0x400. Redirects must also be accepted while stall=1.
- PIPE_TARGET=1:
  - br_req with base 0x20, imm 2. Required: fetch_valid=0 and redirect_busy=1 for 1 cycle, then pc=0x28.
  - Repeat with exc_req=1 asserted in TGT_WAIT: pc=exc_vec and branch dropped.
- Wrap/misalign:
  - pc=0xFFFF_FFFC advances to 0x0.
  - jmp_target=0x102: pc=0x100 with misalign pulsing 1 cycle.
  - Assert rst_n low in TGT_WAIT: pc=RESET_VEC, redirect_busy=0.

Source files
------------

// File: rtl/pc_gen_unit_pkg.sv
// Shared CPU-core constants: default widths, reset vector, PC-unit state encoding
// and the redirect-source encoding used by the PC generator.
package cpu_pkg;

    localparam int          CPU_DATA_W     = 32;
    localparam int          CPU_INST_BYTES = 4;
    localparam int          CPU_IMM_SHIFT  = 2;
    localparam logic [31:0] CPU_RESET_VEC  = 32'h0000_0000;

    // PC-unit FSM encoding, kept as plain constants for legacy tools
    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_TGT_WAIT = 2'd2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch handshake and redirect bundle between the PC generator (master) and the
// rest of the pipeline (slave).
interface pc_gen_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
);
    // Handshake: pc is transferred on an edge where fetch_valid & fetch_ready & !stall.
    // While fetch_valid is high and no transfer occurs, pc stays stable. Redirects
    // are not handshaked: br_req/jmp_req/exc_req are taken on the edge they are high,
    // except that br_req/jmp_req must stay low while redirect_busy is high.
    logic              fetch_valid;
    logic              fetch_ready;
    logic              stall;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus;
    logic              br_req;
    logic [DATA_W-1:0] br_base;
    logic [DATA_W-1:0] br_imm;
    logic              jmp_req;
    logic [DATA_W-1:0] jmp_target;
    logic              exc_req;
    logic [DATA_W-1:0] exc_vec;
    logic              redirect_busy;
    logic              misalign;

    modport master (
        output fetch_valid, pc, pc_plus, redirect_busy, misalign,
        input  fetch_ready, stall, br_req, br_base, br_imm,
               jmp_req, jmp_target, exc_req, exc_vec
    );

    modport slave (
        input  fetch_valid, pc, pc_plus, redirect_busy, misalign,
        output fetch_ready, stall, br_req, br_base, br_imm,
               jmp_req, jmp_target, exc_req, exc_vec
    );

endinterface

// File: rtl/pc_gen_unit_target_adder.sv
// Combinational branch-target adder: base + (imm << IMM_SHIFT), modulo 2^DATA_W.
module pc_target_adder
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int IMM_SHIFT = CPU_IMM_SHIFT
) (
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] target
);

    assign target = base + (imm << IMM_SHIFT);

endmodule

// File: rtl/pc_gen_unit.sv
// Registered program-counter generator: sequential fetch with stall/handshake,
// prioritised exception/jump/branch redirects and an optional one-cycle target pipe.
module pc_gen_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W      = CPU_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VEC   = DATA_W'(CPU_RESET_VEC),
    parameter int                INST_BYTES  = CPU_INST_BYTES,
    parameter int                IMM_SHIFT   = CPU_IMM_SHIFT,
    parameter bit                PIPE_TARGET = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_gen_unit_if.master  bus,
    output logic [1:0]     dbg_state
);

    localparam logic [DATA_W-1:0] INST_INC   = DATA_W'(INST_BYTES);
    localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(INST_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              busy_q, busy_d;
    logic              misalign_q, misalign_d;

    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] raw_target;
    logic [DATA_W-1:0] load_target;
    logic              load;
    redir_src_e        src;

    pc_target_adder #(
        .DATA_W    (DATA_W),
        .IMM_SHIFT (IMM_SHIFT)
    ) u_target_adder (
        .base   (bus.br_base),
        .imm    (bus.br_imm),
        .target (br_target)
    );

    always_comb begin
        src        = SRC_NONE;
        raw_target = '0;
        if (bus.exc_req) begin
            src        = SRC_EXC;
            raw_target = bus.exc_vec;
        end else if (bus.jmp_req) begin
            src        = SRC_JMP;
            raw_target = bus.jmp_target;
        end else if (bus.br_req) begin
            src        = SRC_BR;
            raw_target = br_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        fetch_valid_d = fetch_valid_q;
        busy_d        = busy_q;
        misalign_d    = 1'b0;
        load          = 1'b0;
        load_target   = raw_target;
        case (state_q)
            ST_BOOT: begin
                fetch_valid_d = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (PIPE_TARGET && (src == SRC_BR)) begin
                    tgt_d         = br_target;
                    fetch_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = ST_TGT_WAIT;
                end else if (src != SRC_NONE) begin
                    load = 1'b1;
                end else if (fetch_valid_q && bus.fetch_ready && !bus.stall) begin
                    pc_d = pc_q + INST_INC;
                end
            end
            ST_TGT_WAIT: begin
                // An exception arriving while the branch target is in flight wins
                load          = 1'b1;
                load_target   = bus.exc_req ? bus.exc_vec : tgt_q;
                fetch_valid_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (load) begin
            pc_d       = load_target & ~ALIGN_MASK;
            misalign_d = |(load_target & ALIGN_MASK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VEC;
            tgt_q         <= '0;
            fetch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            fetch_valid_q <= fetch_valid_d;
            busy_q        <= busy_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_q + INST_INC;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.redirect_busy = busy_q;
    assign bus.misalign      = misalign_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: one instance per PIPE_TARGET setting, shared stimulus,
// a behavioural reference model and per-cycle comparison plus directed literal checks.
module tb_pc_gen_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready = 1'b0;
    logic        stall = 1'b0;
    logic        br_req = 1'b0;
    logic [31:0] br_base = '0;
    logic [31:0] br_imm = '0;
    logic        jmp_req = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_vec = '0;
    logic [1:0]  dbg_state0, dbg_state1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_gen_unit_if #(.DATA_W(32)) bus0 ();
    pc_gen_unit_if #(.DATA_W(32)) bus1 ();

    assign bus0.fetch_ready = fetch_ready;  assign bus1.fetch_ready = fetch_ready;
    assign bus0.stall       = stall;        assign bus1.stall       = stall;
    assign bus0.br_req      = br_req;       assign bus1.br_req      = br_req;
    assign bus0.br_base     = br_base;      assign bus1.br_base     = br_base;
    assign bus0.br_imm      = br_imm;       assign bus1.br_imm      = br_imm;
    assign bus0.jmp_req     = jmp_req;      assign bus1.jmp_req     = jmp_req;
    assign bus0.jmp_target  = jmp_target;   assign bus1.jmp_target  = jmp_target;
    assign bus0.exc_req     = exc_req;      assign bus1.exc_req     = exc_req;
    assign bus0.exc_vec     = exc_vec;      assign bus1.exc_vec     = exc_vec;

    pc_gen_unit #(.PIPE_TARGET(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0.master),
        .dbg_state (dbg_state0)
    );

    pc_gen_unit #(.PIPE_TARGET(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1.master),
        .dbg_state (dbg_state1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [31:0] model_branch(input logic [31:0] base, input logic [31:0] imm);
        longint sum;
        sum = longint'(base) + longint'(imm) * 4;
        return 32'(sum);
    endfunction

    function automatic logic [31:0] model_align(input logic [31:0] t);
        return (t / 4) * 4;
    endfunction

    // index 0: target applied same cycle; index 1: branch target one cycle later
    logic [31:0] m_pc[2]   = '{32'h0, 32'h0};
    logic        m_fv[2]   = '{1'b0, 1'b0};
    logic        m_mis[2]  = '{1'b0, 1'b0};
    logic        m_boot[2] = '{1'b1, 1'b1};
    logic        m_pend[2] = '{1'b0, 1'b0};
    logic [31:0] m_tgt[2]  = '{32'h0, 32'h0};
    logic        started   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        for (int p = 0; p < 2; p++) begin
            logic [31:0] t;
            logic        do_load;
            do_load = 1'b0;
            t       = '0;
            if (!rst_n) begin
                m_pc[p] = 32'h0; m_fv[p] = 1'b0; m_mis[p] = 1'b0;
                m_boot[p] = 1'b1; m_pend[p] = 1'b0;
            end else if (m_boot[p]) begin
                m_boot[p] = 1'b0; m_fv[p] = 1'b1; m_mis[p] = 1'b0;
            end else if (m_pend[p]) begin
                chk("proto_no_br_jmp_while_busy", 32'({br_req, jmp_req}), 32'h0);
                t = exc_req ? exc_vec : m_tgt[p];
                do_load = 1'b1; m_pend[p] = 1'b0; m_fv[p] = 1'b1;
            end else if (exc_req) begin
                t = exc_vec; do_load = 1'b1;
            end else if (jmp_req) begin
                t = jmp_target; do_load = 1'b1;
            end else if (br_req && p == 1) begin
                m_tgt[p] = model_branch(br_base, br_imm); m_pend[p] = 1'b1;
                m_fv[p] = 1'b0; m_mis[p] = 1'b0;
            end else if (br_req) begin
                t = model_branch(br_base, br_imm); do_load = 1'b1;
            end else begin
                m_mis[p] = 1'b0;
                if (m_fv[p] && fetch_ready && !stall) m_pc[p] = m_pc[p] + 32'd4;
            end
            if (do_load) begin
                m_pc[p]  = model_align(t);
                m_mis[p] = (t % 4) != 0;
            end
        end
        if (rst_n) started = 1'b1;
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (started || !rst_n) begin
            chk("p0_pc",      bus0.pc,                    m_pc[0]);
            chk("p0_pc_plus", bus0.pc_plus,               m_pc[0] + 32'd4);
            chk("p0_valid",   32'(bus0.fetch_valid),      32'(m_fv[0]));
            chk("p0_busy",    32'(bus0.redirect_busy),    32'h0);
            chk("p0_misalign",32'(bus0.misalign),         32'(m_mis[0]));
            chk("p1_pc",      bus1.pc,                    m_pc[1]);
            chk("p1_pc_plus", bus1.pc_plus,               m_pc[1] + 32'd4);
            chk("p1_valid",   32'(bus1.fetch_valid),      32'(m_fv[1]));
            chk("p1_busy",    32'(bus1.redirect_busy),    32'(m_pend[1]));
            chk("p1_misalign",32'(bus1.misalign),         32'(m_mis[1]));
            chk("p1_tgt_wait_state", 32'(dbg_state1 == ST_TGT_WAIT), 32'(m_pend[1]));
            chk("p0_never_wait",     32'(dbg_state0 == ST_TGT_WAIT), 32'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        br_req = 1'b0; jmp_req = 1'b0; exc_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_ready = 1'b1;
        chk("mdl_branch_neg", model_branch(32'h100, 32'hFFFF_FFFC), 32'hF0);
        chk("mdl_branch_pos", model_branch(32'h100, 32'h40), 32'h200);
        chk("mdl_align",      model_align(32'h102), 32'h100);
        tick(); tick();
        chk("rst_pc0", bus0.pc, 32'h0);
        chk("rst_fv0", 32'(bus0.fetch_valid), 32'h0);
        chk("rst_pc1", bus1.pc, 32'h0);
        chk("rst_busy1", 32'(bus1.redirect_busy), 32'h0);

        rst_n = 1'b1;
        tick();
        chk("boot_fv0", 32'(bus0.fetch_valid), 32'h1);
        chk("boot_pc0", bus0.pc, 32'h0);
        tick(); chk("seq_pc4",  bus0.pc, 32'h4);
        tick(); chk("seq_pc8",  bus0.pc, 32'h8);
        tick(); chk("seq_pc12", bus0.pc, 32'hC);
        tick(); chk("seq_pc16", bus0.pc, 32'h10);

        fetch_ready = 1'b0;
        repeat (3) begin tick(); chk("not_ready_hold", bus0.pc, 32'h10); end
        fetch_ready = 1'b1; stall = 1'b1;
        repeat (2) begin tick(); chk("stall_hold", bus0.pc, 32'h10); end
        stall = 1'b0;
        tick(); chk("stall_release", bus0.pc, 32'h14);

        br_req = 1'b1; br_base = 32'h100; br_imm = 32'hFFFF_FFFC;
        tick(); clear_redirects();
        chk("br_neg_p0", bus0.pc, 32'hF0);
        chk("br_neg_p1_valid", 32'(bus1.fetch_valid), 32'h0);
        tick();
        chk("br_neg_p1", bus1.pc, 32'hF0);

        br_req = 1'b1; br_base = 32'h100; br_imm = 32'h40;
        tick(); clear_redirects();
        chk("br_pos_p0", bus0.pc, 32'h200);
        tick();

        br_req = 1'b1; br_base = 32'h20; br_imm = 32'h2;
        tick(); clear_redirects();
        chk("pipe_busy",  32'(bus1.redirect_busy), 32'h1);
        chk("pipe_valid", 32'(bus1.fetch_valid), 32'h0);
        tick();
        chk("pipe_pc", bus1.pc, 32'h28);
        chk("pipe_busy_clear", 32'(bus1.redirect_busy), 32'h0);

        stall = 1'b1;
        exc_req = 1'b1; jmp_req = 1'b1; br_req = 1'b1;
        exc_vec = 32'h80; jmp_target = 32'h400;
        tick();
        chk("prio_exc_p0", bus0.pc, 32'h80);
        chk("prio_exc_p1", bus1.pc, 32'h80);
        exc_req = 1'b0;
        tick(); clear_redirects();
        chk("prio_jmp_p0", bus0.pc, 32'h400);
        chk("prio_jmp_p1", bus1.pc, 32'h400);
        stall = 1'b0;

        br_req = 1'b1; br_base = 32'h20; br_imm = 32'h2;
        tick(); clear_redirects();
        chk("drop_busy", 32'(bus1.redirect_busy), 32'h1);
        exc_req = 1'b1; exc_vec = 32'h80;
        tick(); clear_redirects();
        chk("drop_exc_pc", bus1.pc, 32'h80);
        tick();
        chk("drop_next_pc", bus1.pc, 32'h84);

        jmp_req = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick(); clear_redirects();
        chk("wrap_top", bus0.pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", bus0.pc, 32'h0);

        jmp_req = 1'b1; jmp_target = 32'h102;
        tick(); clear_redirects();
        chk("mis_pc",    bus0.pc, 32'h100);
        chk("mis_pulse", 32'(bus0.misalign), 32'h1);
        tick();
        chk("mis_clear", 32'(bus0.misalign), 32'h0);

        br_req = 1'b1; br_base = 32'h20; br_imm = 32'h2;
        tick(); clear_redirects();
        chk("rst_wait_busy", 32'(bus1.redirect_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_pc",   bus1.pc, 32'h0);
        chk("rst_mid_busy", 32'(bus1.redirect_busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 15);
            fetch_ready = $urandom_range(0, 3) != 0;
            stall       = $urandom_range(0, 4) == 0;
            exc_req     = (r == 0);
            jmp_req     = (r == 1 || r == 2) && !m_pend[1];
            br_req      = (r >= 3 && r <= 5) && !m_pend[1];
            exc_vec     = $urandom & 32'h0000_FFFF;
            jmp_target  = $urandom;
            br_base     = $urandom;
            br_imm      = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255))
                                                      : -32'($urandom_range(0, 255));
            tick();
        end
        clear_redirects();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
